// File: rtl/fp_add_sched.sv
// Two-requester scheduler sharing one combinational bfloat16 adder: round-robin
// grant, one op per two cycles, per-requester result buffer. Optional FP_ADD_SCHED_STICKY_EN.

module fp_add_rsp_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_i,
  input  logic        drain_i,
  input  logic [15:0] sum_i,
  input  logic [2:0]  flags_i,
  output logic        valid_o,
  output logic [15:0] sum_o,
  output logic [2:0]  flags_o
`ifdef FP_ADD_SCHED_STICKY_EN
  ,
  input  logic        stat_clr_i,
  output logic [2:0]  stat_o
`endif
);
  logic        vld_q;
  logic [15:0] sum_q;
  logic [2:0]  flg_q;

  // A capture on the same edge as a drain keeps the buffer full with new data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      sum_q <= 16'h0000;
      flg_q <= 3'b000;
    end else if (cap_i) begin
      vld_q <= 1'b1;
      sum_q <= sum_i;
      flg_q <= flags_i;
    end else if (vld_q && drain_i) begin
      vld_q <= 1'b0;
    end
  end

  assign valid_o = vld_q;
  assign sum_o   = sum_q;
  assign flags_o = flg_q;

`ifdef FP_ADD_SCHED_STICKY_EN
  logic [2:0] stat_q;

  // Clear first, then OR in the capture, so a same-cycle capture survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stat_q <= 3'b000;
    else        stat_q <= (stat_clr_i ? 3'b000 : stat_q) | (cap_i ? flags_i : 3'b000);
  end

  assign stat_o = stat_q;
`endif
endmodule

module fp_add_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_sum,
  output logic [2:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_sum,
  output logic [2:0]  rsp1_flags,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  input  logic [2:0]  add_flags
`ifdef FP_ADD_SCHED_STICKY_EN
  ,
  input  logic        stat_clr,
  output logic [5:0]  stat_flags
`endif
);
  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t      state_q;
  logic        ptr_q, owner_q;
  logic [15:0] a_q, b_q;

  logic [NUM_LANES-1:0]            req_vld, rsp_rdy, rsp_vld, elig, gnt_oh, cap;
  logic [NUM_LANES-1:0][15:0]      req_a, req_b, rsp_sum;
  logic [NUM_LANES-1:0][2:0]       rsp_flg;
  logic                            gnt_idx, accept;

  assign req_vld = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign req_a   = {req1_a, req0_a};
  assign req_b   = {req1_b, req0_b};

  // A full buffer only blocks its own requester, and only until it is being drained.
  assign elig    = req_vld & (~rsp_vld | rsp_rdy);
  assign gnt_idx = (&elig) ? ~ptr_q : elig[1];
  assign accept  = reset && (state_q == IDLE) && (|elig);
  assign gnt_oh  = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign req0_ready = gnt_oh[0];
  assign req1_ready = gnt_oh[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: if (|elig) begin
          a_q     <= req_a[gnt_idx];
          b_q     <= req_b[gnt_idx];
          owner_q <= gnt_idx;
          ptr_q   <= gnt_idx;
          state_q <= EXEC;
        end
        EXEC: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a = a_q;
  assign add_b = b_q;

`ifdef FP_ADD_SCHED_STICKY_EN
  logic [NUM_LANES-1:0][2:0] stat;
  assign stat_flags = stat;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign cap[gi] = (state_q == EXEC) && (owner_q == gi[0]);

    fp_add_rsp_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .cap_i      (cap[gi]),
      .drain_i    (rsp_rdy[gi]),
      .sum_i      (add_sum),
      .flags_i    (add_flags),
      .valid_o    (rsp_vld[gi]),
      .sum_o      (rsp_sum[gi]),
      .flags_o    (rsp_flg[gi])
`ifdef FP_ADD_SCHED_STICKY_EN
      ,
      .stat_clr_i (stat_clr),
      .stat_o     (stat[gi])
`endif
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_sum   = rsp_sum[0];
  assign rsp1_sum   = rsp_sum[1];
  assign rsp0_flags = rsp_flg[0];
  assign rsp1_flags = rsp_flg[1];
endmodule

// File: doc/fp_add_sched.md
FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 The module SHALL have these ports, clock and reset first (N = 0, 1):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  requester N has an operand pair.
- reqN_ready  out  1  scheduler accepts requester N's pair this cycle.
- reqN_a, reqN_b  in  16  bfloat16 operands: sign[15], exponent[14:7], mantissa[6:0].
- rspN_valid  out  1  result buffer N is full.
- rspN_ready  in  1  requester N takes its result.
- rspN_sum  out  16  bfloat16 sum.
- rspN_flags  out  3  {overflow, underflow, inexact}.
- add_a, add_b  out  16  operands driven to the shared combinational bfloat16 adder.
- add_sum  in  16  adder sum, valid in the same cycle as add_a/add_b.
- add_flags  in  3  adder {overflow, underflow, inexact}.

Function
REQ-002 The FSM SHALL have two states: IDLE (arbitrate) and EXEC (adder busy); reset state IDLE.
REQ-003 In IDLE, requester N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-004 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: if both are eligible, grant the one not last granted; if one is eligible, grant it; pointer reset value 1, so requester 0 wins the first tie.
REQ-005 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, and at most one reqN_ready SHALL be high per cycle.
REQ-006 On acceptance the pair SHALL be registered into the operand registers driving add_a/add_b, the grant SHALL be registered as owner, the pointer SHALL update to the owner, and the FSM SHALL go to EXEC.
REQ-007 In EXEC, add_sum/add_flags SHALL be captured into result buffer [owner], rsp[owner]_valid SHALL be set, and the FSM SHALL return to IDLE unconditionally.
REQ-008 Latency SHALL be: accept at edge k, rspN_valid=1 after edge k+1; peak throughput one operation per 2 cycles.
REQ-009 rspN_valid SHALL clear on a cycle with rspN_valid=1 and rspN_ready=1, unless the same edge writes a new result into buffer N, in which case it stays 1 with new data.
REQ-010 rspN_sum/rspN_flags SHALL hold stable while rspN_valid=1 and rspN_ready=0.
REQ-011 add_a/add_b SHALL keep the last accepted operands outside EXEC; no adder output is sampled in IDLE.
REQ-012 A requester with a full, undrained buffer SHALL NOT block the other requester.
REQ-013 Deasserting reqN_valid while not granted SHALL have no effect; no request is queued internally.

Reset
REQ-014 While reset=0, asynchronously: FSM=IDLE, pointer=1, owner=0, reqN_ready=0, rspN_valid=0, rspN_sum=16'h0000, rspN_flags=3'b000, add_a=add_b=16'h0000, plus stat registers if compiled in.
REQ-015 Reset asserted during EXEC SHALL abandon the operation with no result delivered; the first accept after release SHALL follow REQ-004 with pointer=1.

Configuration
REQ-016 Macro FP_ADD_SCHED_STICKY_EN defined: ports stat_clr (in, 1) and stat_flags (out, 6, {req1 flags, req0 flags}) SHALL exist; each captured flag bit is ORed into stat_flags for its owner, cleared to 0 by stat_clr=1 on the next edge, with a same-cycle capture winning over the clear.
REQ-017 Macro not defined: stat_clr/stat_flags and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-018 Single op: after reset, req0 a=16'h3F80, b=16'h3F80 valid; adder model returns 16'h4000 -> req0_ready one cycle, rsp0_valid=1 two edges later, rsp0_sum=16'h4000, flags=000.
REQ-019 Fairness: both requesters valid continuously with rsp ready=1 -> grants alternate 0,1,0,1, one grant per 2 cycles.
REQ-020 Backpressure: rsp0_ready=0 with rsp0 full, both valid -> only requester 1 is granted; rsp0_sum unchanged; req0 served in the cycle after rsp0_ready=1.
REQ-021 Drain-and-refill: rsp1_valid=1, rsp1_ready=1 on the capture edge of a new req1 result -> rsp1_valid stays 1, data updated, no result lost.
REQ-022 Reset mid-op: reset=0 during EXEC -> all outputs reach REQ-014 values immediately; no rsp_valid after release until a new accept.
REQ-023 With FP_ADD_SCHED_STICKY_EN: adder returns overflow=1 for req1 -> stat_flags=6'b100000; stat_clr=1 -> 6'b000000 next edge.
